fetch_decode_queue: RTL
=======================

# fetch_decode_queue

Instruction queue between the fetch unit and the decode stage. It captures each fetched {pc, instruction, pc+4} triple in a small circular FIFO. It presents the oldest entry to decode with a valid/ready handshake and drives fetch back-pressure when full. It discards all queued entries when a branch is taken, so wrong-path instructions never reach decode.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high
- flush  input  1  branch taken; empties the queue (wired to the same signal that redirects fetch)
- enq_valid  input  1  fetch presents a new entry this cycle
- enq_pc  input  32  PC of the fetched instruction
- enq_instr  input  32  instruction word from instruction memory
- enq_pc_plus4  input  32  PC + 4 from fetch
- full  output  1  count == DEPTH; drives fetch's stall input
- deq_ready  input  1  decode can accept the head entry this cycle
- deq_valid  output  1  queue non-empty
- deq_pc  output  32  head PC; 0 when empty
- deq_instr  output  32  head instruction; 0x00000013 (NOP) when empty
- deq_pc_plus4  output  32  head PC+4; 0 when empty
- count  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage is DEPTH entries of 96 bits. wr_ptr and rd_ptr are each $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in a count register.
- Enqueue fires when enq_valid && !full && !flush. The entry is written at wr_ptr, and wr_ptr increments.
- Dequeue fires when deq_valid && deq_ready && !flush. rd_ptr increments.
- Enqueue and dequeue in the same cycle: both pointers advance and count is unchanged.
- When full, an enqueue is rejected even if a dequeue fires the same cycle. There is no pass-through, and full is computed from registered count only. The fetch unit holds its PC while full is high, so the rejected entry is re-presented.
- Flush has priority over everything. On the next edge: wr_ptr = rd_ptr = 0 and count = 0. Any same-cycle enqueue is dropped and any same-cycle dequeue is ignored. Decode must treat the head shown during a flush cycle as squashed.
- The deq_* outputs are combinational reads of entry[rd_ptr], masked to the empty values (0 / NOP / 0) when count == 0.
- full = (count == DEPTH); deq_valid = (count != 0). Both come directly from registered count.
- Storage contents are not reset. Masking guarantees stale data is never visible.
- Every enqueued entry is dequeued exactly once, in order, unless a flush removes it.

## Timing
- Reset (asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0, full = 0, deq_valid = 0, deq_pc = 0, deq_instr = 0x00000013, deq_pc_plus4 = 0.
- Reset asserted mid-operation empties the queue immediately, without waiting for a clock edge. The first enqueue after release lands in entry 0.
- Latency: an entry enqueued on edge N is visible on deq_* with deq_valid = 1 after edge N; decode can take it at edge N+1.
- full rises after the edge that makes count == DEPTH. It falls after the first edge on which a dequeue fires without an enqueue.
- After a flush edge: count = 0, full = 0 and deq_valid = 0. Fetch may enqueue the branch-target instruction on the following edge.
- Throughput: one enqueue and one dequeue per cycle in steady state.

## Test plan
- Reset, then idle: deq_valid = 0, deq_instr = 0x00000013, deq_pc = 0, full = 0, count = 0.
- Enqueue pc = 0x00, 0x04, 0x08, 0x0C on four edges with deq_ready = 0: full = 1 and count = 4 after the fourth edge. A fifth enqueue of pc = 0x10 is rejected. Then deq_ready = 1 dequeues 0x00, 0x04, 0x08, 0x0C in order, with deq_pc_plus4 = pc + 4 each time.
- Full queue with enq_valid = 1 (pc = 0x10) and deq_ready = 1 on the same edge: 0x00 leaves, 0x10 is not written, and count goes to 3.
- Two entries queued, then flush = 1 with enq_valid = 1 (pc = 0x40) and deq_ready = 1: after the edge, count = 0 and deq_valid = 0. Next edge enqueues pc = 0x80, which appears at the head.
- Stream 10 entries with enqueue and dequeue firing every cycle (pc = 0x00..0x24): the output order matches the input order across pointer wrap-around, and count stays at 1.
- Reset asserted asynchronously mid-cycle with 3 entries queued: the outputs go to their reset values before the next clock edge, and the next enqueue appears as the head with count = 1.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Circular instruction queue between fetch and decode; head is a combinational read, so an entry is visible the cycle after it is written.
// Fetch is back-pressured by full (from registered count only); flush empties the queue on the next edge.
module fetch_decode_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  logic [31:0]                enq_pc,
  input  logic [31:0]                enq_instr,
  input  logic [31:0]                enq_pc_plus4,
  output logic                       full,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_instr,
  output logic [31:0]                deq_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          enq_fire;
  logic          deq_fire;

  assign full      = (count == CW'(DEPTH));
  assign deq_valid = (count != '0);
  assign enq_fire  = enq_valid && !full && !flush;
  assign deq_fire  = deq_valid && deq_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
      if (enq_fire && !deq_fire)      count <= count + CW'(1);
      else if (deq_fire && !enq_fire) count <= count - CW'(1);
    end
  end

  // Storage is deliberately unreset; the empty mask below hides stale entries.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[wr_ptr] <= '{pc: enq_pc, instr: enq_instr, pc_plus4: enq_pc_plus4};
  end

  assign head         = mem[rd_ptr];
  assign deq_pc       = deq_valid ? head.pc       : 32'h0;
  assign deq_instr    = deq_valid ? head.instr    : NOP;
  assign deq_pc_plus4 = deq_valid ? head.pc_plus4 : 32'h0;

endmodule
